mmio_io_bridge: RTL and testbench
=================================

MMIO_IO_BRIDGE -- requirements
Module: mmio_io_bridge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning bus data width (multiple of 8).
REQ-002 SHALL have parameter NUM_SW, default 16, meaning switch inputs (1..DATA_WIDTH).
REQ-003 SHALL have parameter NUM_LED, default 16, meaning LED outputs (1..DATA_WIDTH).
REQ-004 SHALL have parameter NUM_BTN, default 4, meaning push-button inputs (1..8).
REQ-005 SHALL have parameter NUM_DIGITS, default 4, meaning 7-segment digits (1..8, 4*NUM_DIGITS <= DATA_WIDTH).
REQ-006 SHALL have parameter REFRESH_DIV, default 100000, meaning clk cycles per digit scan step (>= 2).
REQ-007 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning stable cycles before button level accepted (>= 2).
REQ-008 SHALL have ports: clk  in  1  system clock; rst  in  1  asynchronous active-high reset.
REQ-009 SHALL have ports: rd  in  1  read strobe; we  in  DATA_WIDTH/8  byte write enables; addr  in  8  word-aligned register offset; data_in  in  DATA_WIDTH  write data.
REQ-010 SHALL have ports: data_out  out  DATA_WIDTH  read data; rd_valid  out  1  read data valid.
REQ-011 SHALL have ports: sw  in  NUM_SW  raw switches; btn  in  NUM_BTN  raw buttons; led  out  NUM_LED; seg  out  7  active-low segments a..g (bit0 = a); an  out  NUM_DIGITS  active-low digit anodes.

Function
REQ-012 SHALL decode registers: 0x00 LED (RW), 0x04 SW (RO), 0x08 DISP (RW, nibble k = digit k), 0x0C CTRL (RW: bit0 display enable, bits[8+NUM_DIGITS-1:8] digit mask), 0x10 BTN (bits[NUM_BTN-1:0] sticky press flags, W1C; bits[16+NUM_BTN-1:16] debounced level, RO).
REQ-013 SHALL apply writes on the clk edge where any we bit is set, updating only enabled bytes; bits beyond register width ignored.
REQ-014 SHALL register reads: data_out and rd_valid=1 one cycle after rd=1; rd_valid=0 otherwise; data_out holds last value when rd_valid=0.
REQ-015 SHALL return 0 for reads of unmapped or unimplemented bits; writes to unmapped offsets, SW, and BTN level bits have no effect.
REQ-016 SHALL, when rd and we coincide at the same offset, return pre-write value.
REQ-017 SHALL pass sw through a 2-flop synchroniser; SW read returns synchronised value (2-cycle input latency).
REQ-018 SHALL debounce each button: synchronise (2 flops), count consecutive cycles where synced value differs from accepted level, accept new level when count reaches DEBOUNCE_CYCLES-1, reset count on any mismatch break.
REQ-019 SHALL set sticky flag on each accepted 0->1 transition; set takes priority over a simultaneous W1C of the same bit.
REQ-020 SHALL drive led from LED register bits[NUM_LED-1:0] combinationally from the register (zero added latency).
REQ-021 SHALL run refresh counter 0..REFRESH_DIV-1; on wrap advance digit index modulo NUM_DIGITS (NUM_DIGITS-1 wraps to 0).
REQ-022 SHALL drive an one-hot-low at digit index when display enabled and that digit's mask bit set; otherwise all an=1 and seg=7'h7F.
REQ-023 SHALL drive seg with active-low hex glyph (0-F) of the selected DISP nibble, registered with an so both change on the same edge.
REQ-024 SHALL keep refresh counter and digit index running while display disabled.

Reset
REQ-025 SHALL on rst assertion asynchronously clear LED, DISP, BTN flags, debounce state, synchronisers, counters, digit index, data_out, rd_valid; set CTRL to 0x00000F01 masked to NUM_DIGITS (enabled, all digits).
REQ-026 SHALL therefore present led=0, seg=7'h7F, an=all 1, rd_valid=0 during reset; first scan output (digit 0, glyph "0") appears at the first refresh wrap after release.
REQ-027 SHALL abort any in-flight read on reset; no rd_valid pulse after release without new rd.

Structure
REQ-028 SHALL place register offsets, CTRL reset value, and 16-entry hex-to-segment table in shared package/header defines.vh.
REQ-029 SHALL instantiate one sub-module io_debounce (synchroniser + counter + level, parameter DEBOUNCE_CYCLES) per button via generate.

Verification
REQ-030 Byte write: we=4'b0010, addr 0x00, data_in 0x0000AB00 over LED=0x1234 -> led=0xAB34 next cycle; read 0x00 -> rd_valid one cycle later, data_out 0x0000AB34.
REQ-031 Scan: REFRESH_DIV=4, DISP=0x0000C3A5 -> an cycles 1110,1101,1011,0111 every 4 clks with seg glyphs 5,A,3,C; CTRL mask 0x0D01 -> digit 1 blank (an=1111, seg=7F).
REQ-032 Debounce: DEBOUNCE_CYCLES=8, btn[0] bounces 3 cycles then stable high -> BTN level bit16 set exactly 2+8 cycles after stable, flag bit0 set; W1C 0x1 clears flag.
REQ-033 Collision: W1C of bit0 on same edge as new accepted press -> flag remains 1.
REQ-034 Reset mid-operation: assert rst during DISP scan and pending read -> led=0, an=1111, rd_valid=0 immediately; after release read CTRL -> 0x00000F01.
REQ-035 Unmapped: write 0xFFFFFFFF to 0x14 then read 0x14 and 0x04 with sw=0x5A5A -> 0x0 and 0x00005A5A.

Source files
------------

// File: rtl/mmio_io_bridge_pkg.sv
// Shared register map, CTRL reset value and hex glyph table for the MMIO I/O bridge.
package mmio_io_bridge_pkg;

    localparam logic [7:0] REG_LED  = 8'h00;
    localparam logic [7:0] REG_SW   = 8'h04;
    localparam logic [7:0] REG_DISP = 8'h08;
    localparam logic [7:0] REG_CTRL = 8'h0C;
    localparam logic [7:0] REG_BTN  = 8'h10;

    localparam logic [31:0] CTRL_RST = 32'h0000_0F01;
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MASK_LSB = 8;
    localparam int BTN_LVL_LSB   = 16;

    // Active-low a..g (bit0 = a), entry n is the glyph for hex digit n.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/mmio_io_bridge_if.sv
// Register-bus bundle between a CPU-side master and the I/O bridge.
interface mmio_io_bridge_if #(
    parameter int DATA_WIDTH = 32
);
    logic                    rd;
    logic [DATA_WIDTH/8-1:0] we;
    logic [7:0]              addr;
    logic [DATA_WIDTH-1:0]   data_in;
    logic [DATA_WIDTH-1:0]   data_out;
    logic                    rd_valid;

    modport master (output rd, we, addr, data_in, input data_out, rd_valid);
    modport slave  (input rd, we, addr, data_in, output data_out, rd_valid);
endinterface

// File: rtl/mmio_io_bridge_debounce.sv
// One push-button: 2-flop synchroniser, mismatch run counter and accepted level.
module io_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any cycle where the synced input agrees with the level breaks the run.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (s2_q != level_q) begin
            if (cnt_q == CNT_MAX) level_d = s2_q;
            else                  cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= btn_i;
            s2_q    <= s1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = level_d & ~level_q;
endmodule

// File: rtl/mmio_io_bridge.sv
// Memory-mapped bridge to LEDs, switches, debounced buttons and a scanned 7-segment display.
module mmio_io_bridge
    import mmio_io_bridge_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_SW          = 16,
    parameter int NUM_LED         = 16,
    parameter int NUM_BTN         = 4,
    parameter int NUM_DIGITS      = 4,
    parameter int REFRESH_DIV     = 100000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                  clk,
    input  logic                  rst,
    mmio_io_bridge_if.slave       bus,
    input  logic [NUM_SW-1:0]     sw,
    input  logic [NUM_BTN-1:0]    btn,
    output logic [NUM_LED-1:0]    led,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);
    localparam int NBYTE  = DATA_WIDTH / 8;
    localparam int DISP_W = 4 * NUM_DIGITS;
    localparam int RW     = $clog2(REFRESH_DIV);
    localparam logic [RW-1:0] REF_MAX = RW'(REFRESH_DIV - 1);
    localparam logic [2:0]    DIG_MAX = 3'(NUM_DIGITS - 1);

    function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old,
                                                    input logic [DATA_WIDTH-1:0] wd,
                                                    input logic [DATA_WIDTH-1:0] m);
        return (old & ~m) | (wd & m);
    endfunction

    logic [NUM_LED-1:0]    led_q, led_d;
    logic [DISP_W-1:0]     disp_q, disp_d;
    logic                  en_q, en_d;
    logic [NUM_DIGITS-1:0] mask_q, mask_d;
    logic [NUM_BTN-1:0]    flag_q, flag_d, clr;
    logic [NUM_SW-1:0]     sw1_q, sw2_q;
    logic [RW-1:0]         ref_q, ref_d;
    logic [2:0]            dig_q, dig_d;
    logic [NUM_DIGITS-1:0] an_q, an_d, mask_sh;
    logic [6:0]            seg_q, seg_d;
    logic [DISP_W-1:0]     disp_sh;
    logic [DATA_WIDTH-1:0] dout_q, dout_d, rdata, wmask;
    logic [DATA_WIDTH-1:0] led_x, disp_x, ctrl_x, btn_x;
    logic                  rv_q, wr_en, wrap;
    logic [NUM_BTN-1:0]    btn_lvl, btn_rise;

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
        io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk     (clk),
            .rst     (rst),
            .btn_i   (btn[gi]),
            .level_o (btn_lvl[gi]),
            .rise_o  (btn_rise[gi])
        );
    end

    always_comb begin
        for (int b = 0; b < NBYTE; b++) wmask[8*b +: 8] = {8{bus.we[b]}};
    end
    assign wr_en = |bus.we;

    always_comb begin
        led_x  = DATA_WIDTH'(led_q);
        disp_x = DATA_WIDTH'(disp_q);
        ctrl_x = '0;
        ctrl_x[CTRL_EN_BIT] = en_q;
        ctrl_x[CTRL_MASK_LSB +: NUM_DIGITS] = mask_q;
        btn_x = '0;
        btn_x[NUM_BTN-1:0] = flag_q;
        btn_x[BTN_LVL_LSB +: NUM_BTN] = btn_lvl;
    end

    always_comb begin
        case (bus.addr)
            REG_LED:  rdata = led_x;
            REG_SW:   rdata = DATA_WIDTH'(sw2_q);
            REG_DISP: rdata = disp_x;
            REG_CTRL: rdata = ctrl_x;
            REG_BTN:  rdata = btn_x;
            default:  rdata = '0;
        endcase
    end

    // Register updates; a new press beats a same-cycle clear of its flag.
    always_comb begin
        led_d  = led_q;
        disp_d = disp_q;
        en_d   = en_q;
        mask_d = mask_q;
        clr    = '0;
        if (wr_en) begin
            case (bus.addr)
                REG_LED:  led_d  = NUM_LED'(merge(led_x, bus.data_in, wmask));
                REG_DISP: disp_d = DISP_W'(merge(disp_x, bus.data_in, wmask));
                REG_CTRL: begin
                    en_d   = 1'(merge(ctrl_x, bus.data_in, wmask) >> CTRL_EN_BIT);
                    mask_d = NUM_DIGITS'(merge(ctrl_x, bus.data_in, wmask) >> CTRL_MASK_LSB);
                end
                REG_BTN:  clr = bus.data_in[NUM_BTN-1:0] & wmask[NUM_BTN-1:0];
                default:  ;
            endcase
        end
        flag_d = (flag_q & ~clr) | btn_rise;
        dout_d = bus.rd ? rdata : dout_q;
    end

    // The scan outputs latch the digit being left on each wrap, so the
    // visible digit trails dig_q by one step.
    always_comb begin
        wrap    = (ref_q == REF_MAX);
        ref_d   = wrap ? '0 : ref_q + 1'b1;
        dig_d   = dig_q;
        if (wrap) dig_d = (dig_q == DIG_MAX) ? 3'd0 : dig_q + 3'd1;
        mask_sh = mask_q >> dig_q;
        disp_sh = disp_q >> {dig_q, 2'b00};
        an_d    = an_q;
        seg_d   = seg_q;
        if (wrap) begin
            if (en_q && mask_sh[0]) begin
                an_d  = ~(NUM_DIGITS'(1) << dig_q);
                seg_d = HEX_SEG[disp_sh[3:0]];
            end else begin
                an_d  = '1;
                seg_d = 7'h7F;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q  <= '0;
            disp_q <= '0;
            en_q   <= CTRL_RST[CTRL_EN_BIT];
            mask_q <= '1;
            flag_q <= '0;
            sw1_q  <= '0;
            sw2_q  <= '0;
            ref_q  <= '0;
            dig_q  <= '0;
            an_q   <= '1;
            seg_q  <= 7'h7F;
            dout_q <= '0;
            rv_q   <= 1'b0;
        end else begin
            led_q  <= led_d;
            disp_q <= disp_d;
            en_q   <= en_d;
            mask_q <= mask_d;
            flag_q <= flag_d;
            sw1_q  <= sw;
            sw2_q  <= sw1_q;
            ref_q  <= ref_d;
            dig_q  <= dig_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dout_q <= dout_d;
            rv_q   <= bus.rd;
        end
    end

    assign led          = led_q;
    assign seg          = seg_q;
    assign an           = an_q;
    assign bus.data_out = dout_q;
    assign bus.rd_valid = rv_q;
endmodule

// File: tb/tb_mmio_io_bridge.sv
// Randomised and directed bench for mmio_io_bridge against a cycle-count reference model.
module tb_mmio_io_bridge;
    localparam int RD = 4;
    localparam int DC = 8;
    localparam int ND = 4;

    // Active-high gfedcba patterns; the display expects their complement.
    localparam logic [6:0] GLYPH_HI [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] sw;
    logic [3:0]  btn;
    logic [15:0] led;
    logic [6:0]  seg;
    logic [3:0]  an;

    mmio_io_bridge_if #(.DATA_WIDTH(32)) bus ();

    mmio_io_bridge #(
        .DATA_WIDTH(32), .NUM_SW(16), .NUM_LED(16), .NUM_BTN(4), .NUM_DIGITS(ND),
        .REFRESH_DIV(RD), .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .sw(sw), .btn(btn),
        .led(led), .seg(seg), .an(an)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] led_m, disp_m, sw1_m, sw2_m;
    logic        en_m, rv_m;
    logic [3:0]  mask_m, flag_m, lvl_m, an_m;
    logic [6:0]  seg_m;
    logic [31:0] dout_m;
    int          n_m;
    logic [3:0]  bq [$];

    function automatic logic [31:0] reg_val(input logic [7:0] a);
        case (a)
            8'h00:   return {16'h0, led_m};
            8'h04:   return {16'h0, sw2_m};
            8'h08:   return {16'h0, disp_m};
            8'h0C:   return {20'h0, mask_m, 7'h0, en_m};
            8'h10:   return {12'h0, lvl_m, 12'h0, flag_m};
            default: return 32'h0;
        endcase
    endfunction

    // Raw button sample taken at edge i (1-based since reset release); 0 before.
    function automatic logic raw_btn(input int i, input int b);
        if (i < 1) return 1'b0;
        return bq[i-1][b];
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [31:0] wm, nv;
        logic [3:0]  rise, nl;
        logic        flip;
        int          e, d;
        if (rst) begin
            led_m = 0; disp_m = 0; en_m = 1; mask_m = 4'hF; flag_m = 0; lvl_m = 0;
            sw1_m = 0; sw2_m = 0; dout_m = 0; rv_m = 0; an_m = 4'hF; seg_m = 7'h7F;
            n_m = 0; bq.delete();
        end else begin
            n_m++;
            e = n_m;
            rv_m = bus.rd;
            if (bus.rd) dout_m = reg_val(bus.addr);
            if (e % RD == 0) begin
                d = (e / RD - 1) % ND;
                if (en_m && mask_m[d]) begin
                    an_m  = ~(4'b0001 << d);
                    seg_m = ~GLYPH_HI[disp_m[4*d +: 4]];
                end else begin
                    an_m  = 4'hF;
                    seg_m = 7'h7F;
                end
            end
            wm = {{8{bus.we[3]}}, {8{bus.we[2]}}, {8{bus.we[1]}}, {8{bus.we[0]}}};
            nv = (reg_val(bus.addr) & ~wm) | (bus.data_in & wm);
            // Level flips once the last DC synchronised samples all disagree with it.
            rise = 0;
            nl = lvl_m;
            for (int b = 0; b < 4; b++) begin
                flip = 1'b1;
                for (int j = 0; j < DC; j++)
                    if (raw_btn(e - 2 - j, b) == lvl_m[b]) flip = 1'b0;
                if (flip) begin
                    nl[b] = ~lvl_m[b];
                    rise[b] = nl[b];
                end
            end
            bq.push_back(btn);
            sw2_m = sw1_m;
            sw1_m = sw;
            if (|bus.we) begin
                case (bus.addr)
                    8'h00: led_m = nv[15:0];
                    8'h08: disp_m = nv[15:0];
                    8'h0C: begin en_m = nv[0]; mask_m = nv[11:8]; end
                    8'h10: flag_m = flag_m & ~(bus.data_in[3:0] & wm[3:0]);
                    default: ;
                endcase
            end
            flag_m = flag_m | rise;
            lvl_m  = nl;
        end
    end

    always @(negedge clk) begin
        chk("led", {16'h0, led}, {16'h0, led_m});
        chk("an", {28'h0, an}, {28'h0, an_m});
        chk("seg", {25'h0, seg}, {25'h0, seg_m});
        chk("rd_valid", {31'h0, bus.rd_valid}, {31'h0, rv_m});
        chk("data_out", bus.data_out, dout_m);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [3:0] w, input logic [31:0] dat);
        bus.addr = a; bus.we = w; bus.data_in = dat; bus.rd = 1'b0;
        tick();
        bus.we = 4'h0;
    endtask

    task automatic rdchk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        bus.addr = a; bus.we = 4'h0; bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
        chk({tag, "_vld"}, {31'h0, bus.rd_valid}, 32'h1);
        chk(tag, bus.data_out, exp);
    endtask

    task automatic wait_an(input logic [3:0] v);
        int k;
        k = 0;
        while (an !== v && k < 40) begin
            tick();
            k++;
        end
        chk("wait_an", {28'h0, an}, {28'h0, v});
    endtask

    initial begin
        logic [7:0] a;
        logic [3:0] an_seq [4];
        logic [6:0] seg_seq [4];
        an_seq  = '{4'hE, 4'hD, 4'hB, 4'h7};
        seg_seq = '{7'h12, 7'h08, 7'h30, 7'h46};
        sw = 16'h0; btn = 4'h0;
        bus.rd = 1'b0; bus.we = 4'h0; bus.addr = 8'h0; bus.data_in = 32'h0;
        repeat (3) tick();
        chk("rst_led", {16'h0, led}, 32'h0);
        chk("rst_an", {28'h0, an}, 32'hF);
        chk("rst_seg", {25'h0, seg}, 32'h7F);
        chk("rst_rv", {31'h0, bus.rd_valid}, 32'h0);
        rst = 1'b0;

        wr(8'h00, 4'hF, 32'h0000_1234);
        wr(8'h00, 4'b0010, 32'h0000_AB00);
        chk("led_byte", {16'h0, led}, 32'h0000_AB34);
        rdchk("led_rd", 8'h00, 32'h0000_AB34);

        sw = 16'h5A5A;
        wr(8'h14, 4'hF, 32'hFFFF_FFFF);
        tick(); tick();
        rdchk("unmapped", 8'h14, 32'h0);
        rdchk("sw_rd", 8'h04, 32'h0000_5A5A);
        wr(8'h04, 4'hF, 32'hFFFF_FFFF);
        rdchk("sw_ro", 8'h04, 32'h0000_5A5A);

        bus.addr = 8'h00; bus.we = 4'hF; bus.data_in = 32'h5555; bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0; bus.we = 4'h0;
        chk("rw_pre", bus.data_out, 32'h0000_AB34);
        chk("rw_led", {16'h0, led}, 32'h0000_5555);

        wr(8'h08, 4'hF, 32'h0000_C3A5);
        repeat (RD) tick();
        wait_an(4'hE);
        for (int i = 0; i < 4; i++) begin
            chk("scan_an", {28'h0, an}, {28'h0, an_seq[i]});
            chk("scan_seg", {25'h0, seg}, {25'h0, seg_seq[i]});
            repeat (RD) tick();
        end

        wr(8'h0C, 4'hF, 32'h0000_0D01);
        repeat (RD) tick();
        wait_an(4'hE);
        chk("mask_seg0", {25'h0, seg}, 32'h12);
        repeat (RD) tick();
        chk("mask_an1", {28'h0, an}, 32'hF);
        chk("mask_seg1", {25'h0, seg}, 32'h7F);
        repeat (RD) tick();
        chk("mask_an2", {28'h0, an}, 32'hB);
        wr(8'h0C, 4'hF, 32'h0000_0F00);
        repeat (RD + 1) tick();
        chk("dis_an", {28'h0, an}, 32'hF);
        chk("dis_seg", {25'h0, seg}, 32'h7F);
        wr(8'h0C, 4'hF, 32'h0000_0F01);
        repeat (2 * RD) tick();

        btn[0] = 1'b1; tick();
        btn[0] = 1'b0; tick(); tick();
        btn[0] = 1'b1;
        repeat (9) tick();
        rdchk("btn_early", 8'h10, 32'h0);
        rdchk("btn_lvl", 8'h10, 32'h0001_0001);
        wr(8'h10, 4'h1, 32'h1);
        rdchk("btn_w1c", 8'h10, 32'h0001_0000);

        btn[1] = 1'b1;
        repeat (9) tick();
        wr(8'h10, 4'h1, 32'h2);
        rdchk("btn_coll", 8'h10, 32'h0003_0002);
        wr(8'h10, 4'hC, 32'hFFFF_0000);
        rdchk("btn_lvl_ro", 8'h10, 32'h0003_0002);

        bus.addr = 8'h00; bus.rd = 1'b1;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_led", {16'h0, led}, 32'h0);
        chk("arst_an", {28'h0, an}, 32'hF);
        chk("arst_seg", {25'h0, seg}, 32'h7F);
        chk("arst_rv", {31'h0, bus.rd_valid}, 32'h0);
        bus.rd = 1'b0;
        tick(); tick();
        rst = 1'b0;
        repeat (RD - 1) tick();
        chk("first_an_blank", {28'h0, an}, 32'hF);
        chk("first_rv", {31'h0, bus.rd_valid}, 32'h0);
        tick();
        chk("first_an", {28'h0, an}, 32'hE);
        chk("first_seg", {25'h0, seg}, 32'h40);
        rdchk("ctrl_rst", 8'h0C, 32'h0000_0F01);

        for (int c = 0; c < 1500; c++) begin
            bus.rd = ($urandom_range(0, 2) == 0);
            bus.we = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            case ($urandom_range(0, 6))
                0: a = 8'h00;
                1: a = 8'h04;
                2: a = 8'h08;
                3: a = 8'h0C;
                4: a = 8'h10;
                5: a = 8'h14;
                default: a = 8'($urandom);
            endcase
            bus.addr = a;
            bus.data_in = $urandom;
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 15) == 0) btn[b] = ~btn[b];
            if ($urandom_range(0, 7) == 0) sw = 16'($urandom);
            tick();
        end
        bus.rd = 1'b0; bus.we = 4'h0;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
